serial_subtractor_ctrl: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal range 2..32.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request a subtraction; sampled only in IDLE.
REQ-006 Port A  input  WIDTH  minuend; sampled on the edge where start is accepted.
REQ-007 Port B  input  WIDTH  subtrahend; sampled on the edge where start is accepted.
REQ-008 Port busy  output  1  high while bit-serial processing is in progress.
REQ-009 Port done  output  1  single-cycle pulse marking that the result is valid.
REQ-010 Port diff  output  WIDTH  registered result of A-B modulo 2^WIDTH.
REQ-011 Port borrow  output  1  registered final borrow; 1 when A<B unsigned.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch A and B into shift registers, clear the internal borrow flop and bit counter, and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-015 Each SHIFT cycle SHALL process one bit, LSB first, using a 1-bit datapath of two cascaded half subtractors plus an OR. Equations: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-016 Each SHIFT cycle SHALL shift the operand registers right by one and shift d into the MSB of the result register.
REQ-017 The block SHALL stay in SHIFT for exactly WIDTH cycles, then enter DONE.
REQ-018 busy SHALL be 1 in cycles k+1..k+WIDTH (SHIFT) and 0 otherwise.
REQ-019 done SHALL be 1 for exactly one cycle, k+WIDTH+1 (DONE), after which the FSM returns to IDLE unconditionally.
REQ-020 On the edge entering DONE, diff and borrow SHALL be updated from the result register and final borrow. They SHALL hold that value until the next entry to DONE or reset.
REQ-021 start SHALL be ignored in SHIFT and DONE, and no pending request is remembered.
REQ-022 A new start is accepted no earlier than the IDLE cycle following DONE. Minimum initiation interval is WIDTH+2 cycles.
REQ-023 A and B changes after acceptance SHALL have no effect on the running operation.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and clear busy, done, diff, borrow, the counter, the operand registers and the internal borrow flop, overriding start.
REQ-025 Reset during SHIFT SHALL abort the operation with no done pulse; diff and borrow read 0.
REQ-026 With rst and start both high on the same edge, reset SHALL win and the request SHALL be dropped.

Configuration
REQ-027 Macro SERIAL_SUB_SAT_EN SHALL select unsigned saturating subtraction.
REQ-028 When SERIAL_SUB_SAT_EN is defined and the final borrow is 1, diff SHALL be loaded with 0 on entering DONE; borrow SHALL still report 1.
REQ-029 When SERIAL_SUB_SAT_EN is undefined, diff SHALL be the wrap-around result modulo 2^WIDTH; timing is identical in both builds.

Verification (WIDTH=8)
REQ-030 Basic subtraction: A=0x5A, B=0x23, start for 1 cycle -> busy high 8 cycles, done in cycle 9, diff=0x37, borrow=0.
REQ-031 Underflow: A=0x23, B=0x5A -> borrow=1; diff=0xC9 without SERIAL_SUB_SAT_EN, diff=0x00 with it.
REQ-032 Edge values: 0xFF-0xFF -> diff=0x00, borrow=0; 0x00-0x01 -> diff=0xFF (0x00 if SAT), borrow=1.
REQ-033 Start while busy: start=1 held through SHIFT with A/B changing -> exactly one done pulse, result from the first latched operands; a new operation starts only from IDLE.
REQ-034 Reset mid-operation: rst pulsed in SHIFT cycle 4 -> next cycle busy=0, done=0, diff=0x00, borrow=0; no done pulse follows; a subsequent start completes normally.
REQ-035 Back-to-back: start held continuously -> done pulses every WIDTH+2=10 cycles, each with the correct result.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A-B controller: LSB-first, one bit per cycle, borrow out.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero on underflow.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] r_q;
  logic             br_q;
  logic [CW-1:0]    cnt;

  logic             last;
  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] r_n;

  assign last = (cnt == CW'(WIDTH - 1));
  assign d    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_n = (~a_q[0] & b_q[0])
              | (~(a_q[0] ^ b_q[0]) & br_q);
  // r_n is the full result once the last bit lands in the MSB
  assign r_n  = {d, r_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      br_q   <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q  <= A;
            b_q  <= B;
            r_q  <= '0;
            br_q <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_q  <= {1'b0, a_q[WIDTH-1:1]};
          b_q  <= {1'b0, b_q[WIDTH-1:1]};
          r_q  <= r_n[WIDTH-1:1];
          br_q <= br_n;
          cnt  <= cnt + CW'(1);
          if (last) begin
`ifdef SERIAL_SUB_SAT_EN
            diff <= br_n ? '0 : r_n;
`else
            diff <= r_n;
`endif
            borrow <= br_n;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8).
// Expected results are queued at issue and checked on each done pulse.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] sb[$];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Hand-computed wrap result and borrow; SAT build clamps to zero.
  function automatic logic [W:0] ex(input logic [W-1:0] wrap,
                                    input logic br);
`ifdef SERIAL_SUB_SAT_EN
    return {br, br ? {W{1'b0}} : wrap};
`else
    return {br, wrap};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        chk("result", 32'({borrow, diff}), 32'(e));
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W:0] e);
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(e);
    step();
    start = 1'b0;
    A = ~a;
    B = ~b;
    for (int i = 0; i < W; i++) begin
      chk("busy_shift", 32'({busy, done}), 32'b10);
      step();
    end
    chk("done_cycle", 32'({busy, done}), 32'b01);
    step();
    chk("idle_after", 32'({busy, done}), 32'b00);
    chk("hold", 32'({borrow, diff}), 32'(e));
  endtask

  initial begin
    int dn;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    step();
    step();
    chk("reset_out", 32'({busy, done, borrow, diff}), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_start", 32'({busy, done}), 32'b00);

    op(8'h5A, 8'h23, ex(8'h37, 1'b0));
    op(8'h23, 8'h5A, ex(8'hC9, 1'b1));
    op(8'hFF, 8'hFF, ex(8'h00, 1'b0));
    op(8'h00, 8'h01, ex(8'hFF, 1'b1));

    // start held through the whole op with noisy operands
    A = 8'h80;
    B = 8'h01;
    start = 1'b1;
    sb.push_back(ex(8'h7F, 1'b0));
    step();
    dn = 0;
    for (int i = 0; i <= W; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      if (done) dn++;
      step();
    end
    start = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (done) dn++;
      step();
    end
    chk("one_done_busy_start", 32'(dn), 32'd1);

    // reset in SHIFT cycle 4 aborts with no done
    A = 8'hAA;
    B = 8'h11;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out", 32'({busy, done, borrow, diff}), 32'd0);
    dn = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (done || busy) dn++;
      step();
    end
    chk("abort_quiet", 32'(dn), 32'd0);
    op(8'hC8, 8'h64, ex(8'h64, 1'b0));

    // reset beats a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    A = 8'h01;
    B = 8'h02;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_wins", 32'({busy, done}), 32'b00);
    step();
    chk("rst_wins_idle", 32'({busy, done}), 32'b00);

    // back-to-back with start held: done every W+2 cycles
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      unique case (j)
        0: begin A = 8'h10; B = 8'h20; sb.push_back(ex(8'hF0, 1'b1)); end
        1: begin A = 8'h64; B = 8'h32; sb.push_back(ex(8'h32, 1'b0)); end
        default: begin A = 8'h01; B = 8'h00; sb.push_back(ex(8'h01, 1'b0)); end
      endcase
      step();
      for (int i = 0; i < W; i++) begin
        chk("b2b_busy", 32'({busy, done}), 32'b10);
        step();
      end
      chk("b2b_done", 32'({busy, done}), 32'b01);
      step();
    end
    start = 1'b0;
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
